// File: rtl/ysyx_22050598_rf_wb_arbiter.sv
// ysyx_22050598_rf_wb_arbiter
// Shares the single register-file write port between EXU results and LSU load
// returns. LSU has fixed priority; an anti-starvation counter forces an EXU win
// after STARVE_MAX consecutive denials. One outstanding load destination is
// tracked so decode can be stalled on read-after-write hazards.
// Optional feature: define YSYX_22050598_WB_BYPASS_EN to forward the write-stage
// value instead of stalling on it (pending loads still stall).
module ysyx_22050598_rf_wb_arbiter #(
  parameter int XLEN       = 64,
  parameter int STARVE_MAX = 4    // legal range 1..15
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            exu_valid,
  input  logic [4:0]      exu_rd,
  input  logic [XLEN-1:0] exu_data,
  output logic            exu_ready,
  input  logic            lsu_valid,
  input  logic [4:0]      lsu_rd,
  input  logic [XLEN-1:0] lsu_data,
  output logic            lsu_ready,
  input  logic            ld_issue_valid,
  input  logic [4:0]      ld_issue_rd,
  output logic            ld_issue_ready,
  input  logic [4:0]      raddr1,
  input  logic [4:0]      raddr2,
  output logic            stall,
  output logic            fwd1_valid,
  output logic            fwd2_valid,
  output logic [XLEN-1:0] fwd_data,
  output logic            rf_wen,
  output logic [4:0]      rf_waddr,
  output logic [XLEN-1:0] rf_wdata
);

  localparam logic [0:0] IDLE      = 1'b0;
  localparam logic [0:0] LOAD_WAIT = 1'b1;

  localparam logic [3:0] CNT_MAX = 4'(STARVE_MAX);

  logic [3:0]      cnt;
  logic [0:0]      state;
  logic [4:0]      pend_rd;

  logic            grant_lsu;
  logic            grant_exu;
  logic            any_grant;
  logic [4:0]      win_rd;
  logic [XLEN-1:0] win_data;

  // Arbitration: LSU first unless EXU has been denied STARVE_MAX times in a row.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    grant_lsu = 1'b0;
    grant_exu = 1'b0;
    win_rd    = exu_rd;
    win_data  = exu_data;
    if (lsu_valid && !(exu_valid && cnt == CNT_MAX)) begin
      grant_lsu = 1'b1;
      win_rd    = lsu_rd;
      win_data  = lsu_data;
    end else if (exu_valid) begin
      grant_exu = 1'b1;
    end
  end

  assign any_grant = grant_lsu | grant_exu;
  assign exu_ready = grant_exu;
  assign lsu_ready = grant_lsu;

  // Starvation counter: counts EXU denials, clears on an EXU win, holds when idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together.
      cnt <= '0;
    end else if (exu_valid) begin
      if (grant_exu)           cnt <= '0;
      else if (cnt != CNT_MAX) cnt <= cnt + 4'd1;
    end
  end

  // Write stage: registers the winner; x0 writes are accepted but suppressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_wen   <= 1'b0;
      rf_waddr <= '0;
      rf_wdata <= '0;
    end else if (any_grant) begin
      rf_wen   <= (win_rd != 5'd0);
      rf_waddr <= win_rd;
      rf_wdata <= win_data;
    end else begin
      rf_wen   <= 1'b0;
    end
  end

  // Load tracker: one outstanding load; a return whose lsu_rd differs from
  // pend_rd is a protocol error upstream, but the write is still performed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pend_rd <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A new issue wins over a same-cycle LSU grant: both happen, we end waiting.
          if (ld_issue_valid && ld_issue_rd != 5'd0) begin
            state   <= LOAD_WAIT;
            pend_rd <= ld_issue_rd;
          end
        end
        default: begin
          if (grant_lsu) state <= IDLE;
        end
      endcase
    end
  end

  assign ld_issue_ready = (state == IDLE);

  function automatic logic hit_pend(input logic [4:0] r);
    return (r != 5'd0) && (state == LOAD_WAIT) && (r == pend_rd);
  endfunction

  function automatic logic hit_wb(input logic [4:0] r);
    return (r != 5'd0) && rf_wen && (r == rf_waddr);
  endfunction

`ifdef YSYX_22050598_WB_BYPASS_EN
  // Hazards: write-stage hits are forwarded, only the pending load stalls.
  always_comb begin
    stall      = hit_pend(raddr1) | hit_pend(raddr2);
    fwd1_valid = hit_wb(raddr1);
    fwd2_valid = hit_wb(raddr2);
    fwd_data   = rf_wdata;
  end
`else
  // Hazards: both pending-load and write-stage hits stall; no forwarding.
  always_comb begin
    stall      = hit_pend(raddr1) | hit_pend(raddr2) | hit_wb(raddr1) | hit_wb(raddr2);
    fwd1_valid = 1'b0;
    fwd2_valid = 1'b0;
    fwd_data   = '0;
  end
`endif

endmodule

// File: tb/tb_ysyx_22050598_rf_wb_arbiter.sv
// Directed testbench for ysyx_22050598_rf_wb_arbiter (XLEN=64, STARVE_MAX=4).
// Works with or without YSYX_22050598_WB_BYPASS_EN defined.
module tb_ysyx_22050598_rf_wb_arbiter;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            exu_valid;
  logic [4:0]      exu_rd;
  logic [XLEN-1:0] exu_data;
  logic            exu_ready;
  logic            lsu_valid;
  logic [4:0]      lsu_rd;
  logic [XLEN-1:0] lsu_data;
  logic            lsu_ready;
  logic            ld_issue_valid;
  logic [4:0]      ld_issue_rd;
  logic            ld_issue_ready;
  logic [4:0]      raddr1;
  logic [4:0]      raddr2;
  logic            stall;
  logic            fwd1_valid;
  logic            fwd2_valid;
  logic [XLEN-1:0] fwd_data;
  logic            rf_wen;
  logic [4:0]      rf_waddr;
  logic [XLEN-1:0] rf_wdata;

  int total = 0;
  int bad   = 0;

`ifdef YSYX_22050598_WB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  ysyx_22050598_rf_wb_arbiter #(.XLEN(XLEN), .STARVE_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .exu_valid(exu_valid), .exu_rd(exu_rd), .exu_data(exu_data), .exu_ready(exu_ready),
    .lsu_valid(lsu_valid), .lsu_rd(lsu_rd), .lsu_data(lsu_data), .lsu_ready(lsu_ready),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd), .ld_issue_ready(ld_issue_ready),
    .raddr1(raddr1), .raddr2(raddr2), .stall(stall),
    .fwd1_valid(fwd1_valid), .fwd2_valid(fwd2_valid), .fwd_data(fwd_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata)
  );

  always #5 clk = ~clk;

  // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    exu_valid = 0; exu_rd = 0; exu_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0;
    raddr1 = 0; raddr2 = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    #12;
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL reset_wen got=%b exp=0", rf_wen); end
    total++; if (rf_waddr !== 5'd0) begin bad++; $display("FAIL reset_waddr got=%0d exp=0", rf_waddr); end
    total++; if (rf_wdata !== 64'd0) begin bad++; $display("FAIL reset_wdata got=%h exp=0", rf_wdata); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL reset_stall got=%b exp=0", stall); end
    total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("FAIL reset_ld_ready got=%b exp=1", ld_issue_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_exu_write();
    exu_valid = 1; exu_rd = 5'd5; exu_data = 64'h1234; raddr1 = 5'd5;
    #1;
    total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL exu_ready got=%b exp=1", exu_ready); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL exu_same_cycle_stall got=%b exp=0", stall); end
    tick();
    exu_valid = 0;
    #1;
    total++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd5, 64'h1234})
      begin bad++; $display("FAIL exu_write got=%b/%0d/%h exp=1/5/1234", rf_wen, rf_waddr, rf_wdata); end
    total++; if (stall !== !BYPASS) begin bad++; $display("FAIL exu_wb_stall got=%b exp=%b", stall, !BYPASS); end
    total++; if (fwd1_valid !== BYPASS) begin bad++; $display("FAIL exu_fwd1 got=%b exp=%b", fwd1_valid, BYPASS); end
    total++; if (fwd_data !== (BYPASS ? 64'h1234 : 64'd0))
      begin bad++; $display("FAIL exu_fwd_data got=%h exp=%h", fwd_data, BYPASS ? 64'h1234 : 64'd0); end
    tick();
    total++; if (rf_wen !== 1'b0 || stall !== 1'b0)
      begin bad++; $display("FAIL exu_drain got=wen%b/stall%b exp=0/0", rf_wen, stall); end
    raddr1 = 0;
  endtask

  task automatic test_load();
    ld_issue_valid = 1; ld_issue_rd = 5'd7;
    #1;
    total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("FAIL ld_ready_idle got=%b exp=1", ld_issue_ready); end
    tick();
    // Issue while waiting must be ignored.
    ld_issue_rd = 5'd9; raddr2 = 5'd7;
    #1;
    total++; if (ld_issue_ready !== 1'b0) begin bad++; $display("FAIL ld_ready_wait got=%b exp=0", ld_issue_ready); end
    total++; if (stall !== 1'b1) begin bad++; $display("FAIL ld_pend_stall got=%b exp=1", stall); end
    tick();
    ld_issue_valid = 0; raddr2 = 5'd9;
    #1;
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_ignored_issue got=%b exp=0", stall); end
    raddr2 = 5'd7; lsu_valid = 1; lsu_rd = 5'd7; lsu_data = 64'hAB;
    #1;
    total++; if (lsu_ready !== 1'b1 || stall !== 1'b1)
      begin bad++; $display("FAIL ld_return got=rdy%b/stall%b exp=1/1", lsu_ready, stall); end
    tick();
    lsu_valid = 0;
    #1;
    total++; if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 64'hAB})
      begin bad++; $display("FAIL ld_write got=%b/%0d/%h exp=1/7/ab", rf_wen, rf_waddr, rf_wdata); end
    total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("FAIL ld_back_idle got=%b exp=1", ld_issue_ready); end
    total++; if (stall !== !BYPASS || fwd2_valid !== BYPASS)
      begin bad++; $display("FAIL ld_wb_hazard got=stall%b/fwd2%b exp=%b/%b", stall, fwd2_valid, !BYPASS, BYPASS); end
    tick();
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL ld_clear got=%b exp=0", stall); end
    raddr2 = 0;
  endtask

  task automatic test_starvation();
    logic exp_exu;
    exu_valid = 1; exu_rd = 5'd10; exu_data = 64'h10;
    lsu_valid = 1; lsu_rd = 5'd20; lsu_data = 64'h20;
    for (int i = 0; i < 10; i++) begin
      exp_exu = (i % 5 == 4);
      #1;
      total++; if ({exu_ready, lsu_ready} !== {exp_exu, !exp_exu})
        begin bad++; $display("FAIL starve_grant[%0d] got=exu%b/lsu%b exp=%b/%b", i, exu_ready, lsu_ready, exp_exu, !exp_exu); end
      tick();
      total++; if (rf_waddr !== (exp_exu ? 5'd10 : 5'd20))
        begin bad++; $display("FAIL starve_waddr[%0d] got=%0d exp=%0d", i, rf_waddr, exp_exu ? 10 : 20); end
    end
    clear_inputs();
    tick();
  endtask

  task automatic test_rd_zero();
    exu_valid = 1; exu_rd = 5'd0; exu_data = 64'hFF;
    #1;
    total++; if (exu_ready !== 1'b1) begin bad++; $display("FAIL rd0_ready got=%b exp=1", exu_ready); end
    tick();
    exu_valid = 0; raddr1 = 5'd0;
    ld_issue_valid = 1; ld_issue_rd = 5'd0;
    #1;
    total++; if (rf_wen !== 1'b0 || rf_waddr !== 5'd0)
      begin bad++; $display("FAIL rd0_wen got=%b/%0d exp=0/0", rf_wen, rf_waddr); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL rd0_stall got=%b exp=0", stall); end
    tick();
    ld_issue_valid = 0;
    #1;
    total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("FAIL rd0_load_idle got=%b exp=1", ld_issue_ready); end
  endtask

  task automatic test_issue_with_return();
    // IDLE: LSU grant and new issue in the same cycle; FSM ends waiting on the new rd.
    lsu_valid = 1; lsu_rd = 5'd11; lsu_data = 64'h5;
    ld_issue_valid = 1; ld_issue_rd = 5'd6;
    tick();
    clear_inputs();
    raddr1 = 5'd6;
    #1;
    total++; if (ld_issue_ready !== 1'b0 || stall !== 1'b1)
      begin bad++; $display("FAIL same_cycle got=rdy%b/stall%b exp=0/1", ld_issue_ready, stall); end
    total++; if (rf_wen !== 1'b1 || rf_waddr !== 5'd11)
      begin bad++; $display("FAIL same_cycle_write got=%b/%0d exp=1/11", rf_wen, rf_waddr); end
    lsu_valid = 1; lsu_rd = 5'd6; lsu_data = 64'h66;
    tick();
    clear_inputs();
    tick();
    total++; if (ld_issue_ready !== 1'b1 || stall !== 1'b0)
      begin bad++; $display("FAIL same_cycle_done got=rdy%b/stall%b exp=1/0", ld_issue_ready, stall); end
  endtask

  task automatic test_async_reset();
    ld_issue_valid = 1; ld_issue_rd = 5'd3;
    exu_valid = 1; exu_rd = 5'd8; exu_data = 64'h1;
    tick();
    clear_inputs();
    raddr1 = 5'd3; raddr2 = 5'd8;
    #1;
    total++; if (stall !== 1'b1 || rf_wen !== 1'b1)
      begin bad++; $display("FAIL pre_reset got=stall%b/wen%b exp=1/1", stall, rf_wen); end
    rst_n = 1'b0;
    #1;
    total++; if (rf_wen !== 1'b0) begin bad++; $display("FAIL async_wen got=%b exp=0", rf_wen); end
    total++; if (ld_issue_ready !== 1'b1) begin bad++; $display("FAIL async_ld_ready got=%b exp=1", ld_issue_ready); end
    total++; if (stall !== 1'b0) begin bad++; $display("FAIL async_stall got=%b exp=0", stall); end
    @(negedge clk);
    rst_n = 1'b1;
    clear_inputs();
    tick();
  endtask

  initial begin
    test_reset();
    test_exu_write();
    test_load();
    test_starvation();
    test_rd_zero();
    test_issue_with_return();
    test_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_22050598_rf_wb_arbiter.md
Name: ysyx_22050598_rf_wb_arbiter

Overview:
- Owns the single write port of the integer register file and shares it between two writeback sources: EXU (single-cycle ALU results) and LSU (load returns).
- Fixed priority goes to LSU, with an anti-starvation counter that guarantees EXU progress.
- Tracks one outstanding load destination (scoreboard) and raises a RAW-hazard stall to decode.
- Sits between EXU/LSU and the register file.

Parameters:
- XLEN, 64, data width.
- STARVE_MAX, 4, consecutive EXU denials before EXU wins arbitration; legal range 1..15.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- exu_valid  in  1  EXU writeback request
- exu_rd  in  5  EXU destination register
- exu_data  in  XLEN  EXU result
- exu_ready  out  1  EXU request accepted this cycle
- lsu_valid  in  1  LSU load-return request
- lsu_rd  in  5  LSU destination register
- lsu_data  in  XLEN  load data
- lsu_ready  out  1  LSU request accepted this cycle
- ld_issue_valid  in  1  load issued with register destination
- ld_issue_rd  in  5  destination of issued load
- ld_issue_ready  out  1  no load outstanding, issue permitted
- raddr1  in  5  decode source register 1
- raddr2  in  5  decode source register 2
- stall  out  1  RAW hazard on raddr1/raddr2
- fwd1_valid  out  1  bypass hit on raddr1 (0 when bypass is compiled out)
- fwd2_valid  out  1  bypass hit on raddr2 (0 when bypass is compiled out)
- fwd_data  out  XLEN  in-flight write data
- rf_wen  out  1  register file write enable
- rf_waddr  out  5  register file write address
- rf_wdata  out  XLEN  register file write data

Behaviour:
- Reset (async, rst_n=0):
  - rf_wen=0, rf_waddr=0, rf_wdata=0.
  - Starvation counter = 0.
  - FSM = IDLE, pend_rd = 0.
  - All combinational outputs then follow from this state: stall=0, ld_issue_ready=1.
  - Reset mid-operation drops any in-flight write and the pending load.
- Arbitration (combinational, one grant per cycle):
  - If lsu_valid and not (exu_valid and cnt==STARVE_MAX): grant LSU.
  - Otherwise, if exu_valid: grant EXU.
  - exu_ready / lsu_ready equal their grant. The ungranted requester holds valid and data stable.
- Counter:
  - Increments when exu_valid and EXU is not granted.
  - Returns to 0 when EXU is granted.
  - Saturates at STARVE_MAX.
  - Holds when exu_valid=0.
- Write stage (registered, 1-cycle latency):
  - On grant: rf_wen <= (rd != 0), rf_waddr <= rd, rf_wdata <= data.
  - With no grant: rf_wen <= 0; address and data hold.
  - rd=0 requests are accepted (ready=1) but never produce rf_wen.
- Load FSM:
  - IDLE: ld_issue_ready=1. ld_issue_valid with rd!=0 → LOAD_WAIT and pend_rd <= ld_issue_rd. ld_issue_valid with rd=0 stays in IDLE.
  - LOAD_WAIT: ld_issue_ready=0; ld_issue_valid is ignored. An LSU grant → IDLE. lsu_rd != pend_rd is a protocol error; the write still proceeds.
  - IDLE with an LSU grant in the same cycle as ld_issue_valid: both take effect, and the FSM ends in LOAD_WAIT with the new rd.
- Hazards (combinational):
  - hitP(r) = r!=0 and FSM==LOAD_WAIT and r==pend_rd.
  - hitW(r) = r!=0 and rf_wen and r==rf_waddr.
  - stall = hitP(raddr1) | hitP(raddr2) | hitW(raddr1) | hitW(raddr2), subject to the bypass rule under Optional Feature.
  - A write granted this cycle is not a hazard until it reaches the write stage next cycle.

Optional Feature:
- Macro: YSYX_22050598_WB_BYPASS_EN.
- Defined:
  - hitW no longer contributes to stall.
  - fwdN_valid = hitW(raddrN).
  - fwd_data = rf_wdata.
  - hitP still stalls.
- Undefined:
  - fwd1_valid = fwd2_valid = 0 and fwd_data = 0.
  - hitW stalls as described in Behaviour.

Test Plan:
- Reset, then exu_valid with rd=5, data=0x1234 → exu_ready=1; next cycle rf_wen=1, rf_waddr=5, rf_wdata=0x1234; raddr1=5 in that cycle → stall=1 (bypass out), or stall=0 with fwd1_valid=1 (bypass in).
- Issue load to rd=7 → ld_issue_ready=0, raddr2=7 gives stall=1. Then lsu_valid with rd=7, data=0xAB → next cycle write x7=0xAB, FSM back in IDLE, stall=0 one cycle later.
- exu_valid and lsu_valid held high continuously, STARVE_MAX=4 → grant pattern LSU,LSU,LSU,LSU,EXU repeating; rf_waddr sequence matches.
- Request with rd=0 from EXU → exu_ready=1, rf_wen stays 0; raddr1=0 → stall=0.
- Load outstanding to rd=3, rst_n pulsed low mid-wait → rf_wen=0, ld_issue_ready=1, stall=0 immediately (asynchronous).
